// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampled
// Description : UART receiver driven by a 16x oversample tick. It has a one-word
//               valid/ready holding register and flags framing, parity and
//               overrun errors.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_oversampled #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int c_TW = $clog2(OVERSAMPLE);
    localparam int c_BW = $clog2(DATA_BITS + 1);
    localparam logic [c_TW-1:0] c_TICK_ONE  = c_TW'(1);
    localparam logic [c_TW-1:0] c_HALF_LAST = c_TW'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TW-1:0] c_FULL_LAST = c_TW'(OVERSAMPLE - 1);
    localparam logic [c_BW-1:0] c_BIT_ONE   = c_BW'(1);
    localparam logic [c_BW-1:0] c_LAST_BIT  = c_BW'(DATA_BITS - 1);
    localparam logic            c_ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nx;
    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic [c_TW-1:0]       r_tick_cnt;
    logic [c_TW-1:0]       w_tick_nx;
    logic [c_BW-1:0]       r_bit_cnt;
    logic [c_BW-1:0]       w_bit_nx;
    logic [DATA_BITS-1:0]  r_shreg;
    logic                  r_perr;
    logic                  r_load_pend;
    logic                  w_shift;
    logic                  w_par_smp;
    logic                  w_load;
    logic                  w_ferr;

    always_comb begin
        w_state_nx = r_state;
        w_tick_nx  = r_tick_cnt;
        w_bit_nx   = r_bit_cnt;
        w_shift    = 1'b0;
        w_par_smp  = 1'b0;
        w_load     = 1'b0;
        w_ferr     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (baud_tick && !r_rx_s) begin
                    w_state_nx = S_START;
                    w_tick_nx  = '0;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    if (r_tick_cnt == c_HALF_LAST) begin
                        // A start bit that is high again at mid-bit was a glitch.
                        w_state_nx = r_rx_s ? S_IDLE : S_DATA;
                        w_tick_nx  = '0;
                        w_bit_nx   = '0;
                    end else begin
                        w_tick_nx = r_tick_cnt + c_TICK_ONE;
                    end
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (r_tick_cnt == c_FULL_LAST) begin
                        w_shift   = 1'b1;
                        w_tick_nx = '0;
                        if (r_bit_cnt == c_LAST_BIT) begin
                            w_state_nx = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            w_bit_nx = r_bit_cnt + c_BIT_ONE;
                        end
                    end else begin
                        w_tick_nx = r_tick_cnt + c_TICK_ONE;
                    end
                end
            end
            S_PARITY: begin
                if (baud_tick) begin
                    if (r_tick_cnt == c_FULL_LAST) begin
                        w_par_smp  = 1'b1;
                        w_tick_nx  = '0;
                        w_state_nx = S_STOP;
                    end else begin
                        w_tick_nx = r_tick_cnt + c_TICK_ONE;
                    end
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    if (r_tick_cnt == c_FULL_LAST) begin
                        w_tick_nx  = '0;
                        w_load     = r_rx_s;
                        w_ferr     = !r_rx_s;
                        w_state_nx = r_rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        w_tick_nx = r_tick_cnt + c_TICK_ONE;
                    end
                end
            end
            S_BREAK: begin
                // Hold off until the line returns high so a break yields one error only.
                if (r_rx_s) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_perr      <= 1'b0;
            r_load_pend <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_rx_meta   <= rx;
            r_rx_s      <= r_rx_meta;
            r_tick_cnt  <= w_tick_nx;
            r_bit_cnt   <= w_bit_nx;
            r_load_pend <= w_load;
            frame_err   <= w_ferr;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            if (w_shift) begin
                r_shreg <= {r_rx_s, r_shreg[DATA_BITS-1:1]};
            end
            if (w_par_smp) begin
                r_perr <= (^r_shreg) ^ r_rx_s ^ c_ODD;
            end
            // A load may coincide with the host draining the previous word.
            if (r_load_pend) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= r_shreg;
                    rx_valid   <= 1'b1;
                    parity_err <= r_perr;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_oversampled
// Description : Directed self-checking bench for uart_rx_oversampled, with one
//               instance without parity and one with even parity.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_oversampled;

    logic       clk = 1'b0;
    logic       reset;
    logic       baud_tick;
    logic       rx0, rx1, ready0, ready1;
    logic [7:0] data0, data1;
    logic       valid0, valid1, pe0, fe0, oe0, pe1, fe1, oe1;

    int n_checks = 0;
    int n_err    = 0;
    int n_pe0 = 0, n_fe0 = 0, n_oe0 = 0, n_pe1 = 0, n_pe1v = 0, n_fe1 = 0, n_oe1 = 0;
    int n_fall0 = 0;
    logic valid0_prev = 1'b0;

    uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx0),
        .rx_data(data0), .rx_valid(valid0), .rx_ready(ready0),
        .parity_err(pe0), .frame_err(fe0), .overrun_err(oe0)
    );

    uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx1),
        .rx_data(data1), .rx_valid(valid1), .rx_ready(ready1),
        .parity_err(pe1), .frame_err(fe1), .overrun_err(oe1)
    );

    always #5 clk = ~clk;

    // One tick every 4th clock, so one bit period is 64 clocks.
    initial begin
        baud_tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 baud_tick = 1'b1;
            @(posedge clk);
            #1 baud_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (pe0) n_pe0 <= n_pe0 + 1;
        if (fe0) n_fe0 <= n_fe0 + 1;
        if (oe0) n_oe0 <= n_oe0 + 1;
        if (pe1) n_pe1 <= n_pe1 + 1;
        if (pe1 && valid1) n_pe1v <= n_pe1v + 1;
        if (fe1) n_fe1 <= n_fe1 + 1;
        if (oe1) n_oe1 <= n_oe1 + 1;
        if (valid0_prev && !valid0) n_fall0 <= n_fall0 + 1;
        valid0_prev <= valid0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input int sel, input logic b);
        if (sel == 0) rx0 = b; else rx1 = b;
        repeat (64) @(posedge clk);
        #1;
    endtask

    // The stop level stays on the line afterwards, so a low stop bit leaves a break.
    task automatic send_frame(input int sel, input logic [7:0] d, input logic use_par,
                              input logic par, input logic stop);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (use_par) drive_bit(sel, par);
        drive_bit(sel, stop);
    endtask

    task automatic wait_valid(input int sel, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if ((sel == 0) ? valid0 : valid1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic ack(input int sel, input string name);
        if (sel == 0) ready0 = 1'b1; else ready1 = 1'b1;
        @(posedge clk);
        #1;
        if (sel == 0) ready0 = 1'b0; else ready1 = 1'b0;
        check(name, 32'((sel == 0) ? valid0 : valid1), 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_fe;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         exp_pe;
    } pvec_t;

    vec_t  vecs[6];
    pvec_t pvecs[5];

    initial begin
        logic ok;
        int   s_fe, s_oe, s_pe, s_pv, s_fall;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
        vecs[3] = '{8'hC3, 1'b0, 1'b0, 8'h00, 1};
        vecs[4] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 0};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 0};
        // Even parity: error when data ones plus parity bit is odd.
        pvecs[0] = '{8'h03, 1'b1, 1};
        pvecs[1] = '{8'h03, 1'b0, 0};
        pvecs[2] = '{8'h07, 1'b1, 0};
        pvecs[3] = '{8'h80, 1'b0, 1};
        pvecs[4] = '{8'hFE, 1'b1, 0};

        reset = 1'b1; rx0 = 1'b1; rx1 = 1'b1; ready0 = 1'b0; ready1 = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_valid0", 32'(valid0), 32'd0);
        check("reset_data0", 32'(data0), 32'd0);
        check("reset_flags0", 32'({pe0, fe0, oe0}), 32'd0);
        check("reset_valid1", 32'(valid1), 32'd0);
        repeat (20) @(posedge clk);
        #1;

        // Table of frames on the parity-free receiver.
        foreach (vecs[k]) begin
            s_fe = n_fe0; s_oe = n_oe0; s_pe = n_pe0;
            send_frame(0, vecs[k].data, 1'b0, 1'b0, vecs[k].stop);
            if (vecs[k].exp_valid) begin
                wait_valid(0, ok);
                check("vec_timeout", 32'(ok), 32'd1);
                check("vec_data", 32'(data0), 32'(vecs[k].exp_data));
            end else begin
                rx0 = 1'b1;
                repeat (100) @(posedge clk);
                #1;
                check("vec_novalid", 32'(valid0), 32'd0);
            end
            check("vec_frame_err", 32'(n_fe0 - s_fe), 32'(vecs[k].exp_fe));
            check("vec_other_err", 32'((n_oe0 - s_oe) + (n_pe0 - s_pe)), 32'd0);
            if (vecs[k].exp_valid) begin
                repeat (10) @(posedge clk);
                #1;
                check("vec_hold_data", 32'(data0), 32'(vecs[k].exp_data));
                ack(0, "vec_ack_fall");
            end
            repeat (30) @(posedge clk);
            #1;
        end

        ready0 = 1'b1;
        repeat (3) @(posedge clk);
        #1 ready0 = 1'b0;
        check("ready_idle_noeffect", 32'(valid0), 32'd0);

        // Short low glitch: START rejects it at mid-bit.
        s_fe = n_fe0;
        rx0 = 1'b0;
        repeat (20) @(posedge clk);
        #1 rx0 = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check("glitch_valid", 32'(valid0), 32'd0);
        check("glitch_flags", 32'(n_fe0 - s_fe), 32'd0);

        // Parity table on the even-parity receiver.
        foreach (pvecs[k]) begin
            s_pe = n_pe1; s_pv = n_pe1v;
            send_frame(1, pvecs[k].data, 1'b1, pvecs[k].par, 1'b1);
            wait_valid(1, ok);
            check("par_timeout", 32'(ok), 32'd1);
            check("par_data", 32'(data1), 32'(pvecs[k].data));
            check("par_err_count", 32'(n_pe1 - s_pe), 32'(pvecs[k].exp_pe));
            check("par_err_with_valid", 32'(n_pe1v - s_pv), 32'(pvecs[k].exp_pe));
            ack(1, "par_ack_fall");
            repeat (30) @(posedge clk);
            #1;
        end
        check("par_no_frame_overrun", 32'(n_fe1 + n_oe1), 32'd0);

        // Break: stop bit low and line held low for 40 ticks.
        s_fe = n_fe0;
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0);
        repeat (160) @(posedge clk);
        #1;
        check("break_valid", 32'(valid0), 32'd0);
        check("break_frame_err_once", 32'(n_fe0 - s_fe), 32'd1);
        rx0 = 1'b1;
        repeat (64) @(posedge clk);
        #1;
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        wait_valid(0, ok);
        check("after_break_timeout", 32'(ok), 32'd1);
        check("after_break_data", 32'(data0), 32'h11);
        check("after_break_fe", 32'(n_fe0 - s_fe), 32'd1);
        ack(0, "after_break_ack");
        repeat (30) @(posedge clk);
        #1;

        // Back-to-back frames with no host acceptance: second word overruns.
        s_oe = n_oe0; s_pe = n_pe0;
        send_frame(0, 8'h01, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h02, 1'b0, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("overrun_data", 32'(data0), 32'h01);
        check("overrun_valid", 32'(valid0), 32'd1);
        check("overrun_pulse", 32'(n_oe0 - s_oe), 32'd1);
        check("overrun_no_perr", 32'(n_pe0 - s_pe), 32'd0);
        ack(0, "overrun_ack");
        repeat (30) @(posedge clk);
        #1;

        // Same pair, ready raised exactly in the second load cycle: frames are
        // 640 clocks long and tick-aligned, so the second load follows the first by 640.
        s_oe = n_oe0;
        fork
            begin
                send_frame(0, 8'h01, 1'b0, 1'b0, 1'b1);
                send_frame(0, 8'h02, 1'b0, 1'b0, 1'b1);
            end
            begin
                wait_valid(0, ok);
                check("coinc_timeout", 32'(ok), 32'd1);
                if (ok) begin
                    s_fall = n_fall0;
                    repeat (639) @(posedge clk);
                    #1 ready0 = 1'b1;
                    @(posedge clk);
                    #1 ready0 = 1'b0;
                    check("coinc_data", 32'(data0), 32'h02);
                    check("coinc_valid", 32'(valid0), 32'd1);
                    check("coinc_no_gap", 32'(n_fall0 - s_fall), 32'd0);
                end
            end
        join
        check("coinc_no_overrun", 32'(n_oe0 - s_oe), 32'd0);
        ack(0, "coinc_ack");
        repeat (30) @(posedge clk);
        #1;

        // Reset in the middle of data bit 3 of 0xFF.
        s_fe = n_fe0; s_oe = n_oe0; s_pe = n_pe0;
        fork
            send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
            begin
                repeat (64 * 4 + 32) @(posedge clk);
                #1 reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
            end
        join
        repeat (100) @(posedge clk);
        #1;
        check("midreset_valid", 32'(valid0), 32'd0);
        check("midreset_flags", 32'((n_fe0 - s_fe) + (n_oe0 - s_oe) + (n_pe0 - s_pe)), 32'd0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        wait_valid(0, ok);
        check("midreset_next_timeout", 32'(ok), 32'd1);
        check("midreset_next_data", 32'(data0), 32'h3C);
        ack(0, "midreset_ack");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
